spi_dbg_burst_engine: RTL and testbench

//  Byte-level debug command engine between the spi_slave byte interface and
//  the qspi_flash read port. Host sends command bytes; engine replies via

---
 rtl/spi_dbg_burst_engine.sv | 237 +++++++++++++++++++++++
 tb/tb_spi_dbg_burst_engine.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_dbg_burst_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_dbg_burst_engine
// Description : Byte-level debug command engine between the SPI slave byte
//               interface and the QSPI flash read port. Supports echo, LED
//               toggle, status query, last-address readback and multi-byte
//               burst reads into an internal buffer with abort.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_dbg_burst_engine #(
  parameter int   ADDR_BYTES = 3,
  parameter int   MAX_BURST  = 16,
  parameter logic LED_RESET  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              recv_data_i,
  input  logic                    recv_ready_i,
  output logic [7:0]              send_data_o,
  input  logic                    flash_setup_done_i,
  output logic [8*ADDR_BYTES-1:0] flash_addr_o,
  output logic                    flash_do_read_o,
  input  logic                    flash_data_ready_i,
  input  logic [7:0]              flash_data_i,
  output logic                    busy_o,
  output logic                    led_o
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  // One extra bit so the counters can hold the value MAX_BURST itself.
  localparam int CW = BW + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_LEN   = 3'd2;
  localparam logic [2:0] S_FETCH = 3'd3;
  localparam logic [2:0] S_REPLY = 3'd4;

  localparam logic [7:0] CMD_ECHO0  = 8'h00;
  localparam logic [7:0] CMD_READ   = 8'h01;
  localparam logic [7:0] CMD_LED    = 8'h02;
  localparam logic [7:0] CMD_ECHOCC = 8'hCC;
  localparam logic [7:0] CMD_STATUS = 8'h20;
  localparam logic [7:0] CMD_ABORT  = 8'h5A;

  logic [2:0]    state_q, state_d;
  logic [7:0]    send_q, send_d;
  logic [AW-1:0] flash_addr_q, flash_addr_d;
  logic          rd_q, rd_d;
  logic          busy_q, busy_d;
  logic          led_q, led_d;
  logic [AW-1:0] last_addr_q, last_addr_d;
  logic [AW-1:0] cur_q, cur_d;
  logic [2:0]    acnt_q, acnt_d;
  logic [CW-1:0] n_q, n_d;
  logic [CW-1:0] fetched_q, fetched_d;
  logic [CW-1:0] pop_q, pop_d;
  logic          sync_q, sync_d;
  logic          w_push;
  logic [8:0]    w_burst;
  logic [AW-1:0] w_shift;
  logic [7:0]    w_lab;
  logic [7:0]    mem_q [MAX_BURST];

  assign send_data_o     = send_q;
  assign flash_addr_o    = flash_addr_q;
  assign flash_do_read_o = rd_q;
  assign busy_o          = busy_q;
  assign led_o           = led_q;

  // Burst length from the host length byte: 0 means one byte, clamp to buffer depth.
  always_comb begin
    w_burst = {1'b0, recv_data_i};
    if (recv_data_i == 8'h00) begin
      w_burst = 9'd1;
    end else if ({1'b0, recv_data_i} > 9'(MAX_BURST)) begin
      w_burst = 9'(MAX_BURST);
    end
  end

  // Byte i of the last issued address for the 0x10+i query; out-of-range bytes read 0.
  always_comb begin
    w_shift = last_addr_q >> {recv_data_i[3:0], 3'b000};
    w_lab   = (int'(recv_data_i[3:0]) < ADDR_BYTES) ? w_shift[7:0] : 8'h00;
  end

  // Command FSM: decodes host bytes, sequences flash reads and drains the buffer.
  always_comb begin
    state_d      = state_q;
    send_d       = send_q;
    flash_addr_d = flash_addr_q;
    rd_d         = rd_q;
    busy_d       = busy_q;
    led_d        = led_q;
    last_addr_d  = last_addr_q;
    cur_d        = cur_q;
    acnt_d       = acnt_q;
    n_d          = n_q;
    fetched_d    = fetched_q;
    pop_d        = pop_q;
    sync_d       = sync_q;
    w_push       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (recv_ready_i) begin
          case (recv_data_i)
            CMD_ECHO0:  send_d = 8'h00;
            CMD_LED: begin
              led_d  = ~led_q;
              send_d = 8'hAB;
            end
            CMD_ECHOCC: send_d = 8'hCC;
            CMD_STATUS: send_d = {flash_setup_done_i, busy_q, 6'b0};
            CMD_READ: begin
              state_d = S_ADDR;
              acnt_d  = 3'(ADDR_BYTES);
              send_d  = 8'(ADDR_BYTES);
            end
            default: send_d = (recv_data_i[7:4] == 4'h1) ? w_lab : 8'hEE;
          endcase
        end
      end
      S_ADDR: begin
        if (recv_ready_i) begin
          // Address arrives MSB first; truncation drops the oldest byte.
          cur_d  = AW'({cur_q, recv_data_i});
          acnt_d = acnt_q - 3'd1;
          send_d = {5'b0, acnt_q - 3'd1};
          if (acnt_q == 3'd1) begin
            state_d = S_LEN;
          end
        end
      end
      S_LEN: begin
        if (recv_ready_i) begin
          n_d       = w_burst[CW-1:0];
          send_d    = w_burst[7:0];
          fetched_d = '0;
          pop_d     = '0;
          sync_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        if (recv_ready_i && (recv_data_i == CMD_ABORT)) begin
          // Abort wins over a same-cycle flash byte; the buffer is discarded.
          send_d    = 8'hFE;
          rd_d      = 1'b0;
          fetched_d = '0;
          pop_d     = '0;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end else begin
          if (recv_ready_i) begin
            send_d = 8'hFE;
          end
          if (rd_q && flash_data_ready_i) begin
            w_push      = 1'b1;
            rd_d        = 1'b0;
            cur_d       = cur_q + AW'(1);
            last_addr_d = flash_addr_q;
            fetched_d   = fetched_q + CW'(1);
            if (fetched_q + CW'(1) == n_q) begin
              state_d = S_REPLY;
            end
          end else if (!rd_q && flash_setup_done_i && (fetched_q < n_q)) begin
            flash_addr_d = cur_q;
            rd_d         = 1'b1;
          end
        end
      end
      S_REPLY: begin
        if (recv_ready_i) begin
          if (!sync_q) begin
            send_d = 8'hFF;
            sync_d = 1'b1;
          end else begin
            send_d = mem_q[pop_q[BW-1:0]];
            pop_d  = pop_q + CW'(1);
            if (pop_q + CW'(1) == n_q) begin
              state_d   = S_IDLE;
              busy_d    = 1'b0;
              sync_d    = 1'b0;
              pop_d     = '0;
              fetched_d = '0;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      send_q       <= 8'h00;
      flash_addr_q <= '0;
      rd_q         <= 1'b0;
      busy_q       <= 1'b0;
      led_q        <= LED_RESET;
      last_addr_q  <= '0;
      cur_q        <= '0;
      acnt_q       <= 3'd0;
      n_q          <= '0;
      fetched_q    <= '0;
      pop_q        <= '0;
      sync_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      send_q       <= send_d;
      flash_addr_q <= flash_addr_d;
      rd_q         <= rd_d;
      busy_q       <= busy_d;
      led_q        <= led_d;
      last_addr_q  <= last_addr_d;
      cur_q        <= cur_d;
      acnt_q       <= acnt_d;
      n_q          <= n_d;
      fetched_q    <= fetched_d;
      pop_q        <= pop_d;
      sync_q       <= sync_d;
    end
  end

  // Burst buffer storage; emptiness is tracked by the counters, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[fetched_q[BW-1:0]] <= flash_data_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_dbg_burst_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_dbg_burst_engine
// Description : Self-checking bench for spi_dbg_burst_engine with a simple
//               flash responder returning addr[7:0] as data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_dbg_burst_engine;

  logic        clk;
  logic        rst;
  logic [7:0]  recv_data;
  logic        recv_ready;
  logic [7:0]  send_data;
  logic        setup_done;
  logic [23:0] flash_addr;
  logic        do_read;
  logic        data_ready;
  logic [7:0]  flash_data;
  logic        busy;
  logic        led;

  int checks;
  int errors;

  logic [23:0] issued [$];
  logic        fl_act;
  logic [1:0]  fl_cnt;
  logic [23:0] fl_cap;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] rep;
    logic       led;
  } vec_t;

  vec_t tbl [11];

  spi_dbg_burst_engine #(
    .ADDR_BYTES (3),
    .MAX_BURST  (16),
    .LED_RESET  (1'b1)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .recv_data_i        (recv_data),
    .recv_ready_i       (recv_ready),
    .send_data_o        (send_data),
    .flash_setup_done_i (setup_done),
    .flash_addr_o       (flash_addr),
    .flash_do_read_o    (do_read),
    .flash_data_ready_i (data_ready),
    .flash_data_i       (flash_data),
    .busy_o             (busy),
    .led_o              (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flash responder: latches a request, answers a few cycles later with addr[7:0].
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fl_act     <= 1'b0;
      fl_cnt     <= 2'd0;
      fl_cap     <= '0;
      data_ready <= 1'b0;
      flash_data <= 8'h00;
    end else begin
      data_ready <= 1'b0;
      if (!fl_act && do_read && !data_ready) begin
        fl_act <= 1'b1;
        fl_cnt <= 2'd2;
        fl_cap <= flash_addr;
        issued.push_back(flash_addr);
      end else if (fl_act) begin
        if (fl_cnt == 2'd0) begin
          data_ready <= 1'b1;
          flash_data <= fl_cap[7:0];
          fl_act     <= 1'b0;
        end else begin
          fl_cnt <= fl_cnt - 2'd1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One SPI byte exchange; returns the reply registered for this byte.
  task automatic xfer(input logic [7:0] b, output logic [7:0] r);
    @(negedge clk);
    recv_data  = b;
    recv_ready = 1'b1;
    @(negedge clk);
    recv_ready = 1'b0;
    r = send_data;
  endtask

  task automatic read_burst(input logic [23:0] a, input logic [7:0] len,
                            input int n_exp, input logic [7:0] n_rep);
    logic [7:0]  r;
    logic [23:0] ea;
    bit          got;
    issued.delete();
    xfer(8'h01, r);    chk("rd_cmd", r, 8'h03);
    xfer(a[23:16], r); chk("rd_a2", r, 8'h02);
    xfer(a[15:8], r);  chk("rd_a1", r, 8'h01);
    xfer(a[7:0], r);   chk("rd_a0", r, 8'h00);
    xfer(len, r);      chk("rd_len", r, n_rep);
    chk("busy_fetch", busy, 1);
    got = 1'b0;
    for (int p = 0; p < 200 && !got; p++) begin
      xfer(8'h00, r);
      if (r != 8'hFE) got = 1'b1;
    end
    if (!got) chk("poll_timeout", 0, 1);
    chk("sync", r, 8'hFF);
    for (int k = 0; k < n_exp; k++) begin
      ea = a + 24'(k);
      chk("busy_reply", busy, 1);
      xfer(8'h77, r);
      chk("data", r, ea[7:0]);
    end
    chk("busy_done", busy, 0);
    chk("issued_cnt", issued.size(), n_exp);
    for (int k = 0; k < n_exp && k < issued.size(); k++) begin
      ea = a + 24'(k);
      chk("issued_addr", issued[k], ea);
    end
  endtask

  initial begin
    logic [7:0] r;
    bit         seen;
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    recv_data  = 8'h00;
    recv_ready = 1'b0;
    setup_done = 1'b1;

    tbl[0]  = '{8'h02, 8'hAB, 1'b0};
    tbl[1]  = '{8'h02, 8'hAB, 1'b1};
    tbl[2]  = '{8'hCC, 8'hCC, 1'b1};
    tbl[3]  = '{8'h00, 8'h00, 1'b1};
    tbl[4]  = '{8'h20, 8'h80, 1'b1};
    tbl[5]  = '{8'h33, 8'hEE, 1'b1};
    tbl[6]  = '{8'h10, 8'h00, 1'b1};
    tbl[7]  = '{8'h12, 8'h00, 1'b1};
    tbl[8]  = '{8'h13, 8'h00, 1'b1};
    tbl[9]  = '{8'h5A, 8'hEE, 1'b1};
    tbl[10] = '{8'hFE, 8'hEE, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_send", send_data, 8'h00);
    chk("rst_addr", flash_addr, 24'h0);
    chk("rst_rd", do_read, 0);
    chk("rst_busy", busy, 0);
    chk("rst_led", led, 1);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      xfer(tbl[i].cmd, r);
      chk("tbl_reply", r, tbl[i].rep);
      chk("tbl_led", led, tbl[i].led);
    end

    // Basic burst of four from 0x000100.
    read_burst(24'h000100, 8'h04, 4, 8'h04);
    xfer(8'h10, r); chk("last_b0", r, 8'h03);
    xfer(8'h11, r); chk("last_b1", r, 8'h01);
    xfer(8'h12, r); chk("last_b2", r, 8'h00);

    // Address wrap at the top of the 24-bit space.
    read_burst(24'hFFFFFE, 8'h03, 3, 8'h03);
    xfer(8'h10, r); chk("wrap_b0", r, 8'h00);
    xfer(8'h12, r); chk("wrap_b2", r, 8'h00);

    // Length 0 means one byte; oversize length clamps to the buffer depth.
    read_burst(24'h000005, 8'h00, 1, 8'h01);
    read_burst(24'h000020, 8'hC8, 16, 8'h10);

    // Abort while stalled on flash_setup_done low.
    setup_done = 1'b0;
    xfer(8'h20, r); chk("status_nosetup", r, 8'h00);
    xfer(8'h01, r); xfer(8'h00, r); xfer(8'h00, r); xfer(8'h00, r);
    xfer(8'h02, r); chk("ab_len", r, 8'h02);
    repeat (4) @(negedge clk);
    chk("ab_stall_rd", do_read, 0);
    chk("ab_busy", busy, 1);
    xfer(8'h20, r); chk("ab_poll", r, 8'hFE);
    xfer(8'h5A, r); chk("ab_reply", r, 8'hFE);
    chk("ab_busy_after", busy, 0);
    chk("ab_rd_after", do_read, 0);
    xfer(8'hCC, r); chk("ab_next", r, 8'hCC);
    setup_done = 1'b1;

    // Asynchronous reset in the middle of a fetch, with led toggled away from reset value.
    xfer(8'h02, r); chk("pre_rst_led", led, 0);
    xfer(8'h01, r); xfer(8'h00, r); xfer(8'h00, r); xfer(8'h40, r);
    xfer(8'h10, r);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (do_read) seen = 1'b1;
    end
    chk("mid_fetch_rd", seen, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_send", send_data, 8'h00);
    chk("arst_addr", flash_addr, 24'h0);
    chk("arst_rd", do_read, 0);
    chk("arst_busy", busy, 0);
    chk("arst_led", led, 1);
    @(negedge clk);
    rst = 1'b0;
    xfer(8'h10, r); chk("arst_last", r, 8'h00);
    xfer(8'h11, r); chk("arst_last1", r, 8'h00);
    xfer(8'hCC, r); chk("arst_idle", r, 8'hCC);
    chk("arst_rd_idle", do_read, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
